video_cfg_ctrl: RTL and testbench

VIDEO_CFG_CTRL -- requirements
Module: video_cfg_ctrl

---
 rtl/video_cfg_ctrl.sv | 170 +++++++++++++++++
 tb/tb_video_cfg_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_cfg_ctrl.sv
// video_cfg_ctrl
// ---------------------------------------------------------------------------
// Decodes a byte-serial MCU command stream and either forwards OSD bytes or
// loads a shadow video configuration. The shadow is copied to the system_*
// outputs on the next vsync falling edge. If no edge arrives within
// APPLY_TIMEOUT cycles, for example because video is stopped, the shadow is
// applied anyway.
//
// Parameters
//   APPLY_TIMEOUT      cycles a pending config waits for vsync before force-apply
// Ports
//   clk                pixel/system clock, rising edge
//   reset              asynchronous, active-high reset
//   mcu_start          1-cycle pulse: begin a new command (aborts any current one)
//   mcu_strobe         1-cycle pulse: mcu_data valid
//   mcu_data[7:0]      command / payload byte
//   vs_n               active-low vertical sync
//   osd_start          start pulse to OSD (cycle after the 0x02 opcode strobe)
//   osd_strobe         byte strobe to OSD (cycle after each payload strobe)
//   osd_data[7:0]      byte to OSD, held between strobes
//   system_scanlines   applied scanline setting
//   system_volume      applied volume setting
//   system_wide_screen applied wide-screen flag
//   cfg_pending        shadow config waiting to be applied
//   cmd_error          sticky unknown-opcode flag, cleared only by reset
// ---------------------------------------------------------------------------
module video_cfg_ctrl #(
  parameter int APPLY_TIMEOUT = 2**20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mcu_start,
  input  logic       mcu_strobe,
  input  logic [7:0] mcu_data,
  input  logic       vs_n,
  output logic       osd_start,
  output logic       osd_strobe,
  output logic [7:0] osd_data,
  output logic [1:0] system_scanlines,
  output logic [1:0] system_volume,
  output logic       system_wide_screen,
  output logic       cfg_pending,
  output logic       cmd_error
);

  localparam int CNT_W = $clog2(APPLY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(APPLY_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, OPCODE, CFG, OSD, IGNORE} state_t;

  state_t           state_reg, state_next;
  logic             osd_start_reg, osd_start_next;
  logic             osd_strobe_reg, osd_strobe_next;
  logic [7:0]       osd_data_reg, osd_data_next;
  logic             error_reg, error_next;
  logic             cfg_write;

  logic [1:0]       shadow_scan_reg, shadow_vol_reg;
  logic             shadow_wide_reg;
  logic [1:0]       sys_scan_reg, sys_vol_reg;
  logic             sys_wide_reg;
  logic             pending_reg;
  logic [CNT_W-1:0] timeout_cnt_reg;
  logic             vs_q_reg;

  logic             vs_fall;
  logic             timeout_hit;
  logic             apply;

  // Command decoder: next state and OSD outputs.
  always_comb begin
    state_next      = state_reg;
    osd_start_next  = 1'b0;
    osd_strobe_next = 1'b0;
    osd_data_next   = osd_data_reg;
    error_next      = error_reg;
    cfg_write       = 1'b0;
    if (mcu_start) begin
      // A strobe coinciding with start belongs to no command and is dropped.
      state_next = OPCODE;
    end else if (mcu_strobe) begin
      case (state_reg)
        OPCODE: begin
          if (mcu_data == 8'h01) begin
            state_next = CFG;
          end else if (mcu_data == 8'h02) begin
            state_next     = OSD;
            osd_start_next = 1'b1;
          end else begin
            state_next = IGNORE;
            error_next = 1'b1;
          end
        end
        CFG: begin
          cfg_write  = 1'b1;
          state_next = IGNORE;
        end
        OSD: begin
          osd_strobe_next = 1'b1;
          osd_data_next   = mcu_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      osd_start_reg  <= 1'b0;
      osd_strobe_reg <= 1'b0;
      osd_data_reg   <= 8'h00;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      osd_start_reg  <= osd_start_next;
      osd_strobe_reg <= osd_strobe_next;
      osd_data_reg   <= osd_data_next;
      error_reg      <= error_next;
    end
  end

  // Apply uses the shadow as it stood before this cycle's write, so a write
  // coinciding with an edge stays pending for the following edge.
  assign vs_fall     = vs_q_reg & ~vs_n;
  assign timeout_hit = (timeout_cnt_reg == CNT_LAST);
  assign apply       = pending_reg & (vs_fall | timeout_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q_reg        <= 1'b1;
      shadow_scan_reg <= 2'b00;
      shadow_vol_reg  <= 2'b10;
      shadow_wide_reg <= 1'b0;
      sys_scan_reg    <= 2'b00;
      sys_vol_reg     <= 2'b10;
      sys_wide_reg    <= 1'b0;
      pending_reg     <= 1'b0;
      timeout_cnt_reg <= '0;
    end else begin
      vs_q_reg <= vs_n;
      if (apply) begin
        sys_scan_reg <= shadow_scan_reg;
        sys_vol_reg  <= shadow_vol_reg;
        sys_wide_reg <= shadow_wide_reg;
      end
      if (cfg_write) begin
        shadow_scan_reg <= mcu_data[1:0];
        shadow_vol_reg  <= mcu_data[3:2];
        shadow_wide_reg <= mcu_data[4];
      end
      pending_reg <= cfg_write | (pending_reg & ~apply);
      if (apply || cfg_write) begin
        timeout_cnt_reg <= '0;
      end else if (pending_reg) begin
        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
      end
    end
  end

  assign osd_start          = osd_start_reg;
  assign osd_strobe         = osd_strobe_reg;
  assign osd_data           = osd_data_reg;
  assign system_scanlines   = sys_scan_reg;
  assign system_volume      = sys_vol_reg;
  assign system_wide_screen = sys_wide_reg;
  assign cfg_pending        = pending_reg;
  assign cmd_error          = error_reg;

endmodule

// File: tb/tb_video_cfg_ctrl.sv
// Testbench for video_cfg_ctrl. Two instances share all inputs: u_dut0 has a
// long timeout (vsync-driven applies), u_dut1 has APPLY_TIMEOUT=16 (timeout
// applies). A transaction-level reference model predicts both.
module tb_video_cfg_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       mcu_start, mcu_strobe, vs_n;
  logic [7:0] mcu_data;

  logic       ostart_o [2];
  logic       ostb_o   [2];
  logic [7:0] odata_o  [2];
  logic [1:0] scan_o   [2];
  logic [1:0] vol_o    [2];
  logic       wide_o   [2];
  logic       pend_o   [2];
  logic       err_o    [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_cfg_ctrl #(.APPLY_TIMEOUT(256)) u_dut0 (
    .clk(clk), .reset(reset), .mcu_start(mcu_start), .mcu_strobe(mcu_strobe),
    .mcu_data(mcu_data), .vs_n(vs_n), .osd_start(ostart_o[0]), .osd_strobe(ostb_o[0]),
    .osd_data(odata_o[0]), .system_scanlines(scan_o[0]), .system_volume(vol_o[0]),
    .system_wide_screen(wide_o[0]), .cfg_pending(pend_o[0]), .cmd_error(err_o[0])
  );

  video_cfg_ctrl #(.APPLY_TIMEOUT(16)) u_dut1 (
    .clk(clk), .reset(reset), .mcu_start(mcu_start), .mcu_strobe(mcu_strobe),
    .mcu_data(mcu_data), .vs_n(vs_n), .osd_start(ostart_o[1]), .osd_strobe(ostb_o[1]),
    .osd_data(odata_o[1]), .system_scanlines(scan_o[1]), .system_volume(vol_o[1]),
    .system_wide_screen(wide_o[1]), .cfg_pending(pend_o[1]), .cmd_error(err_o[1])
  );

  // ---------------- reference model ----------------
  int         tmo [2] = '{256, 16};
  bit         in_cmd;
  int         nbytes;
  logic [7:0] op;
  logic       e_ostart, e_ostb, e_err;
  logic [7:0] e_odata;
  logic [1:0] sh_scan, sh_vol;
  logic       sh_wide;
  logic [1:0] e_scan [2];
  logic [1:0] e_vol  [2];
  logic       e_wide [2];
  logic       e_pend [2];
  int         since  [2];
  logic       vs_prev;
  int         cyc = 0;

  task automatic model_reset();
    in_cmd = 0; nbytes = 0; op = 8'h00;
    e_ostart = 0; e_ostb = 0; e_odata = 8'h00; e_err = 0;
    sh_scan = 2'd0; sh_vol = 2'd2; sh_wide = 0; vs_prev = 1;
    for (int m = 0; m < 2; m++) begin
      e_scan[m] = 2'd0; e_vol[m] = 2'd2; e_wide[m] = 0; e_pend[m] = 0; since[m] = 0;
    end
  endtask

  // Command seen as "bytes since start": byte 0 is the opcode, later bytes
  // are payload interpreted by that opcode.
  task automatic model_edge(input logic st, input logic sb, input logic [7:0] d, input logic vs);
    logic fall, wr;
    fall = vs_prev & ~vs;
    wr = 0;
    e_ostart = 0;
    e_ostb = 0;
    if (st) begin
      in_cmd = 1; nbytes = 0;
    end else if (sb && in_cmd) begin
      if (nbytes == 0) begin
        op = d;
        if (d == 8'h02) e_ostart = 1;
        else if (d != 8'h01) e_err = 1;
      end else if (op == 8'h02) begin
        e_ostb = 1; e_odata = d;
      end else if (op == 8'h01 && nbytes == 1) begin
        wr = 1;
      end
      if (nbytes < 1000) nbytes++;
    end
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (e_pend[m] && (fall || (cyc - since[m] == tmo[m]))) begin
        e_scan[m] = sh_scan; e_vol[m] = sh_vol; e_wide[m] = sh_wide; e_pend[m] = 0;
      end
    end
    if (wr) begin
      sh_scan = d[1:0]; sh_vol = d[3:2]; sh_wide = d[4];
      for (int m = 0; m < 2; m++) begin
        e_pend[m] = 1; since[m] = cyc;
      end
    end
    vs_prev = vs;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic step(input logic st, input logic sb, input logic [7:0] d, input logic vs);
    mcu_start = st; mcu_strobe = sb; mcu_data = d; vs_n = vs;
    @(posedge clk);
    model_edge(st, sb, d, vs);
    #1;
  endtask

  task automatic do_reset();
    mcu_start = 0; mcu_strobe = 0; mcu_data = 8'h00; vs_n = 1;
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if ({ostart_o[m], ostb_o[m], odata_o[m], scan_o[m], vol_o[m], wide_o[m], pend_o[m], err_o[m]}
          !== {1'b0, 1'b0, 8'h00, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset dut%0d: got start=%b stb=%b data=%h scan=%0d vol=%0d wide=%b pend=%b err=%b, want 0 0 00 0 2 0 0 0",
                 m, ostart_o[m], ostb_o[m], odata_o[m], scan_o[m], vol_o[m], wide_o[m], pend_o[m], err_o[m]);
      end
    end
  endtask

  task automatic test_cfg_vsync();
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h1B, 1);
    for (int i = 0; i < 99; i++) step(0, 0, 8'h00, 1);
    n_vec++;
    if (pend_o[0] !== 1'b1 || scan_o[0] !== 2'd0) begin
      n_err++;
      $display("FAIL cfg_wait: pend=%b scan=%0d, want pend=1 scan=0", pend_o[0], scan_o[0]);
    end
    step(0, 0, 8'h00, 0);
    n_vec++;
    if (scan_o[0] !== 2'd3 || vol_o[0] !== 2'd2 || wide_o[0] !== 1'b1 || pend_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_apply: scan=%0d vol=%0d wide=%b pend=%b, want 3 2 1 0",
               scan_o[0], vol_o[0], wide_o[0], pend_o[0]);
    end
    n_vec++;
    if (scan_o[1] !== e_scan[1] || vol_o[1] !== e_vol[1] || wide_o[1] !== e_wide[1] || pend_o[1] !== e_pend[1]) begin
      n_err++;
      $display("FAIL cfg_timeout_unit: scan=%0d vol=%0d wide=%b pend=%b, want %0d %0d %b %b",
               scan_o[1], vol_o[1], wide_o[1], pend_o[1], e_scan[1], e_vol[1], e_wide[1], e_pend[1]);
    end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_osd();
    int starts;
    starts = 0;
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h02, 1);
    starts += int'(ostart_o[0]);
    n_vec++;
    if (ostart_o[0] !== 1'b1 || ostb_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL osd_start: start=%b stb=%b, want 1 0", ostart_o[0], ostb_o[0]);
    end
    step(0, 0, 8'h00, 1);
    starts += int'(ostart_o[0]);
    step(0, 1, 8'hA5, 1);
    starts += int'(ostart_o[0]);
    n_vec++;
    if (ostb_o[0] !== 1'b1 || odata_o[0] !== 8'hA5) begin
      n_err++;
      $display("FAIL osd_byte1: stb=%b data=%h, want 1 a5", ostb_o[0], odata_o[0]);
    end
    step(0, 0, 8'h77, 1);
    starts += int'(ostart_o[0]);
    n_vec++;
    if (ostb_o[0] !== 1'b0 || odata_o[0] !== 8'hA5) begin
      n_err++;
      $display("FAIL osd_hold: stb=%b data=%h, want 0 a5", ostb_o[0], odata_o[0]);
    end
    step(0, 1, 8'h3C, 1);
    starts += int'(ostart_o[0]);
    n_vec++;
    if (ostb_o[0] !== 1'b1 || odata_o[0] !== 8'h3C || starts != 1) begin
      n_err++;
      $display("FAIL osd_byte2: stb=%b data=%h starts=%0d, want 1 3c 1", ostb_o[0], odata_o[0], starts);
    end
    // start during OSD with a strobe in the same cycle: no extra osd_strobe
    step(1, 1, 8'h99, 1);
    n_vec++;
    if (ostb_o[0] !== 1'b0 || odata_o[0] !== 8'h3C) begin
      n_err++;
      $display("FAIL osd_abort: stb=%b data=%h, want 0 3c", ostb_o[0], odata_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h05, 1);
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'hFA, 1);
    step(0, 0, 8'h00, 0);
    n_vec++;
    if (scan_o[0] !== 2'd2 || vol_o[0] !== 2'd2 || wide_o[0] !== 1'b1 || pend_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_apply: scan=%0d vol=%0d wide=%b pend=%b, want 2 2 1 0",
               scan_o[0], vol_o[0], wide_o[0], pend_o[0]);
    end
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    n_vec++;
    if (pend_o[0] !== 1'b0 || scan_o[0] !== 2'd2 || pend_o[1] !== e_pend[1] || scan_o[1] !== e_scan[1]) begin
      n_err++;
      $display("FAIL b2b_once: pend0=%b scan0=%0d pend1=%b scan1=%0d, want 0 2 %b %0d",
               pend_o[0], scan_o[0], pend_o[1], scan_o[1], e_pend[1], e_scan[1]);
    end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_timeout();
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h04, 1);
    for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1);
    n_vec++;
    if (pend_o[1] !== 1'b1 || vol_o[1] !== 2'd2) begin
      n_err++;
      $display("FAIL timeout_early: pend=%b vol=%0d, want 1 2", pend_o[1], vol_o[1]);
    end
    step(0, 0, 8'h00, 1);
    n_vec++;
    if (pend_o[1] !== 1'b0 || vol_o[1] !== 2'd1 || scan_o[1] !== 2'd0 || wide_o[1] !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_apply: pend=%b vol=%0d scan=%0d wide=%b, want 0 1 0 0",
               pend_o[1], vol_o[1], scan_o[1], wide_o[1]);
    end
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    n_vec++;
    if (pend_o[0] !== 1'b0 || vol_o[0] !== 2'd1) begin
      n_err++;
      $display("FAIL timeout_flush: pend=%b vol=%0d, want 0 1", pend_o[0], vol_o[0]);
    end
  endtask

  task automatic test_same_cycle();
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h01, 0);
    n_vec++;
    if (pend_o[0] !== 1'b1 || scan_o[0] !== 2'd0) begin
      n_err++;
      $display("FAIL same_cycle_hold: pend=%b scan=%0d, want 1 0", pend_o[0], scan_o[0]);
    end
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    n_vec++;
    if (pend_o[0] !== 1'b0 || scan_o[0] !== 2'd1 || vol_o[0] !== 2'd0) begin
      n_err++;
      $display("FAIL same_cycle_next: pend=%b scan=%0d vol=%0d, want 0 1 0", pend_o[0], scan_o[0], vol_o[0]);
    end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_bad_opcode();
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h07, 1);
    n_vec++;
    if (err_o[0] !== 1'b1 || ostart_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bad_op_err: err=%b start=%b, want 1 0", err_o[0], ostart_o[0]);
    end
    step(0, 1, 8'h55, 1);
    n_vec++;
    if (ostb_o[0] !== 1'b0 || pend_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bad_op_payload: stb=%b pend=%b, want 0 0", ostb_o[0], pend_o[0]);
    end
    step(1, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    n_vec++;
    if (err_o[0] !== 1'b1 || err_o[1] !== 1'b1 || scan_o[0] !== e_scan[0] || vol_o[0] !== e_vol[0] || wide_o[0] !== e_wide[0]) begin
      n_err++;
      $display("FAIL bad_op_sticky: err=%b/%b scan=%0d vol=%0d wide=%b, want 1/1 %0d %0d %b",
               err_o[0], err_o[1], scan_o[0], vol_o[0], wide_o[0], e_scan[0], e_vol[0], e_wide[0]);
    end
  endtask

  task automatic test_reset_mid_osd();
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h02, 1);
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h1F, 1);
    step(0, 1, 8'hA5, 1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'($urandom), 1);
      n_vec++;
      if (ostb_o[0] !== 1'b0 || ostart_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_strobe: stb=%b start=%b, want 0 0", ostb_o[0], ostart_o[0]);
      end
    end
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if ({ostart_o[m], ostb_o[m], odata_o[m], scan_o[m], vol_o[m], wide_o[m], pend_o[m], err_o[m]}
          !== {1'b0, 1'b0, 8'h00, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL post_reset_state dut%0d: got start=%b stb=%b data=%h scan=%0d vol=%0d wide=%b pend=%b err=%b, want 0 0 00 0 2 0 0 0",
                 m, ostart_o[m], ostb_o[m], odata_o[m], scan_o[m], vol_o[m], wide_o[m], pend_o[m], err_o[m]);
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic st, sb, vs;
      logic [7:0] d;
      st = ($urandom_range(0, 11) == 0);
      sb = ($urandom_range(0, 4) < 2);
      vs = ($urandom_range(0, 19) != 0);
      d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      step(st, sb, d, vs);
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (ostart_o[m] !== e_ostart || ostb_o[m] !== e_ostb || odata_o[m] !== e_odata ||
            scan_o[m] !== e_scan[m] || vol_o[m] !== e_vol[m] || wide_o[m] !== e_wide[m] ||
            pend_o[m] !== e_pend[m] || err_o[m] !== e_err) begin
          n_err++;
          $display("FAIL random dut%0d cyc %0d: got start=%b stb=%b data=%h scan=%0d vol=%0d wide=%b pend=%b err=%b, want %b %b %h %0d %0d %b %b %b",
                   m, cyc, ostart_o[m], ostb_o[m], odata_o[m], scan_o[m], vol_o[m], wide_o[m], pend_o[m], err_o[m],
                   e_ostart, e_ostb, e_odata, e_scan[m], e_vol[m], e_wide[m], e_pend[m], e_err);
        end
      end
    end
  endtask

  initial begin
    mcu_start = 0; mcu_strobe = 0; mcu_data = 8'h00; vs_n = 1; reset = 1;
    test_reset();
    test_cfg_vsync();
    test_osd();
    test_back_to_back();
    test_timeout();
    test_same_cycle();
    test_bad_opcode();
    test_reset_mid_osd();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
